// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the Pmod ENC position/velocity tracker.
//   step_t     : per-cycle step resolution (none / up / down)
//   SAT_WRAP   : position wraps between its limits
//   SAT_CLAMP  : position holds at its limits
//   clamp()    : bounds a signed value into [lo, hi]; used by the load path
//                and by the saturating velocity accumulator
// ---------------------------------------------------------------------------
package enc_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'b00,
        STEP_UP   = 2'b01,
        STEP_DN   = 2'b10
    } step_t;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    function automatic int clamp(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/enc_pulse_sync.sv
// ---------------------------------------------------------------------------
// enc_pulse_sync
// Brings a slow pulse from the divided encoder clock domain into clk and
// turns each rising edge into a single-cycle strobe.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   din   : asynchronous level input (a dirX line from enc)
//   pulse : one clk cycle high per rising edge of din
// ---------------------------------------------------------------------------
module enc_pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic synced;
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs and the chain shifts one stage per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= din;
            synced <= meta;
            prev   <= synced;
        end
    end

    // prev resets to 0, so a line already high when rst drops still
    // produces exactly one strobe.
    assign pulse = synced & ~prev;

endmodule

// File: rtl/enc_position.sv
// ---------------------------------------------------------------------------
// enc_position
// Bounded signed encoder position and windowed velocity derived from the
// dir0/dir1 step pulses of the Pmod ENC decoder.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   dir0      : counter-clockwise step pulse (async to clk)
//   dir1      : clockwise step pulse (async to clk)
//   zero      : synchronous clear of position and limit_hit
//   load      : synchronous load of load_val (clamped) into position
//   load_val  : value for load, two's complement
//   position  : current position, two's complement
//   changed   : one-cycle pulse when position takes a new value
//   limit_hit : sticky; set when a step tries to pass a limit
//   velocity  : net steps in the last complete window, two's complement
//   vel_valid : one-cycle pulse when velocity updates
// ---------------------------------------------------------------------------
module enc_position
    import enc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int POS_MIN    = -128,
    parameter int POS_MAX    = 127,
    parameter int SATURATE   = 0,
    parameter int VEL_WINDOW = 1000000,
    parameter int VW         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir0,
    input  logic             dir1,
    input  logic             zero,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] position,
    output logic             changed,
    output logic             limit_hit,
    output logic [VW-1:0]    velocity,
    output logic             vel_valid
);

    // "Zero" falls back to POS_MIN when 0 is not a legal position.
    localparam int RST_POS = (POS_MIN > 0 || POS_MAX < 0) ? POS_MIN : 0;
    localparam int VEL_MIN = -(2 ** (VW - 1));
    localparam int VEL_MAX = (2 ** (VW - 1)) - 1;
    localparam int WCW     = $clog2(VEL_WINDOW);

    logic     step_up;
    logic     step_dn;
    step_t    step;
    int       step_val;

    int       pos_int;
    int       load_int;
    int       pos_next;
    logic     limit_next;

    logic [WCW-1:0]        win_cnt;
    logic signed [VW-1:0]  acc;
    int                    acc_sum;

    enc_pulse_sync u_sync_dn (
        .clk   (clk),
        .rst   (rst),
        .din   (dir0),
        .pulse (step_dn)
    );

    enc_pulse_sync u_sync_up (
        .clk   (clk),
        .rst   (rst),
        .din   (dir1),
        .pulse (step_up)
    );

    // Simultaneous up and down strobes cancel.
    always_comb begin
        case ({step_dn, step_up})
            2'b01:   step = STEP_UP;
            2'b10:   step = STEP_DN;
            default: step = STEP_NONE;
        endcase
    end

    always_comb begin
        case (step)
            STEP_UP: step_val = 1;
            STEP_DN: step_val = -1;
            default: step_val = 0;
        endcase
    end

    assign pos_int  = int'($signed(position));
    assign load_int = int'($signed(load_val));

    // Priority: zero > load > step.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        pos_next   = pos_int;
        limit_next = limit_hit;
        if (zero) begin
            pos_next   = RST_POS;
            limit_next = 1'b0;
        end else if (load) begin
            pos_next = clamp(load_int, POS_MIN, POS_MAX);
        end else begin
            case (step)
                STEP_UP: begin
                    if (pos_int >= POS_MAX) begin
                        limit_next = 1'b1;
                        pos_next   = (SATURATE == SAT_CLAMP) ? POS_MAX : POS_MIN;
                    end else begin
                        pos_next = pos_int + 1;
                    end
                end
                STEP_DN: begin
                    if (pos_int <= POS_MIN) begin
                        limit_next = 1'b1;
                        pos_next   = (SATURATE == SAT_CLAMP) ? POS_MIN : POS_MAX;
                    end else begin
                        pos_next = pos_int - 1;
                    end
                end
                default: begin
                    pos_next = pos_int;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position  <= WIDTH'(RST_POS);
            changed   <= 1'b0;
            limit_hit <= 1'b0;
        end else begin
            position  <= WIDTH'(pos_next);
            changed   <= (pos_next != pos_int);
            limit_hit <= limit_next;
        end
    end

    // Includes the current cycle's step so the window's final step is not
    // lost when the accumulator restarts.
    assign acc_sum = clamp(int'(acc) + step_val, VEL_MIN, VEL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt   <= '0;
            acc       <= '0;
            velocity  <= '0;
            vel_valid <= 1'b0;
        end else begin
            vel_valid <= 1'b0;
            if (win_cnt == WCW'(VEL_WINDOW - 1)) begin
                win_cnt   <= '0;
                acc       <= '0;
                velocity  <= VW'(acc_sum);
                vel_valid <= 1'b1;
            end else begin
                win_cnt <= win_cnt + WCW'(1);
                acc     <= VW'(acc_sum);
            end
        end
    end

endmodule

// File: tb/tb_enc_position.sv
// ---------------------------------------------------------------------------
// tb_enc_position
// Self-checking bench for enc_position. Four instances:
//   dut_a : 10-bit, [-128,127], wrap, 100-cycle window, 4-bit velocity
//   dut_w : 8-bit, [0,9], wrap      (shares the b_* inputs)
//   dut_s : 8-bit, [0,9], clamp     (shares the b_* inputs)
//   dut_o : 8-bit, [3,12], clamp    (shares the b_* inputs; 0 out of range)
// ---------------------------------------------------------------------------
module tb_enc_position;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut_a signals
    logic       a_dir0, a_dir1, a_zero, a_load;
    logic [9:0] a_load_val, a_position;
    logic       a_changed, a_limit, a_vel_valid;
    logic [3:0] a_velocity;

    // shared stimulus for dut_w / dut_s / dut_o
    logic       b_dir0, b_dir1, b_zero, b_load;
    logic [7:0] b_load_val;
    logic [7:0] w_position, s_position, o_position;
    logic       w_changed, s_changed, o_changed;
    logic       w_limit, s_limit, o_limit;
    logic [7:0] w_velocity, s_velocity, o_velocity;
    logic       w_vel_valid, s_vel_valid, o_vel_valid;

    enc_position #(.WIDTH(10), .POS_MIN(-128), .POS_MAX(127), .SATURATE(0),
                   .VEL_WINDOW(100), .VW(4)) dut_a (
        .clk(clk), .rst(rst), .dir0(a_dir0), .dir1(a_dir1), .zero(a_zero),
        .load(a_load), .load_val(a_load_val), .position(a_position),
        .changed(a_changed), .limit_hit(a_limit), .velocity(a_velocity),
        .vel_valid(a_vel_valid));

    enc_position #(.WIDTH(8), .POS_MIN(0), .POS_MAX(9), .SATURATE(0),
                   .VEL_WINDOW(100), .VW(8)) dut_w (
        .clk(clk), .rst(rst), .dir0(b_dir0), .dir1(b_dir1), .zero(b_zero),
        .load(b_load), .load_val(b_load_val), .position(w_position),
        .changed(w_changed), .limit_hit(w_limit), .velocity(w_velocity),
        .vel_valid(w_vel_valid));

    enc_position #(.WIDTH(8), .POS_MIN(0), .POS_MAX(9), .SATURATE(1),
                   .VEL_WINDOW(100), .VW(8)) dut_s (
        .clk(clk), .rst(rst), .dir0(b_dir0), .dir1(b_dir1), .zero(b_zero),
        .load(b_load), .load_val(b_load_val), .position(s_position),
        .changed(s_changed), .limit_hit(s_limit), .velocity(s_velocity),
        .vel_valid(s_vel_valid));

    enc_position #(.WIDTH(8), .POS_MIN(3), .POS_MAX(12), .SATURATE(1),
                   .VEL_WINDOW(100), .VW(8)) dut_o (
        .clk(clk), .rst(rst), .dir0(b_dir0), .dir1(b_dir1), .zero(b_zero),
        .load(b_load), .load_val(b_load_val), .position(o_position),
        .changed(o_changed), .limit_hit(o_limit), .velocity(o_velocity),
        .vel_valid(o_vel_valid));

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t chg_q[$];
    exp_t vel_q[$];
    int   a_last    = 0;
    bit   vel_check = 1'b0;

    // Scoreboard: every changed / vel_valid pulse of dut_a must match the
    // next expected entry in value and in cycle.
    always @(negedge clk) begin
        if (!rst && a_changed) begin
            if (chg_q.size() == 0) begin
                check("a_changed_unexpected", a_changed, 0);
            end else begin
                exp_t e;
                e = chg_q.pop_front();
                check("a_changed_position", $signed(a_position), e.val);
                check("a_changed_cycle", cyc, e.cyc);
            end
        end
        if (!rst && vel_check && a_vel_valid) begin
            if (vel_q.size() == 0) begin
                check("a_vel_valid_unexpected", a_vel_valid, 0);
            end else begin
                exp_t e;
                e = vel_q.pop_front();
                check("a_velocity", $signed(a_velocity), e.val);
                check("a_vel_valid_cycle", cyc, e.cyc);
            end
        end
    end

    int w_chg_n = 0, s_chg_n = 0, o_chg_n = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (w_changed) w_chg_n++;
            if (s_changed) s_chg_n++;
            if (o_changed) o_chg_n++;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus tasks
    // ---------------------------------------------------------------------
    task automatic push_chg(input int exp_pos, input int at);
        exp_t e;
        if (exp_pos != a_last) begin
            e.val = exp_pos;
            e.cyc = at;
            chg_q.push_back(e);
        end
        a_last = exp_pos;
    endtask

    task automatic push_vel(input int v, input int at);
        exp_t e;
        e.val = v;
        e.cyc = at;
        vel_q.push_back(e);
    endtask

    // dirX high for 3 cycles, low for 3; first sampled at c+1, so the
    // position update lands at edge c+3.
    task automatic a_pulse(input logic up, input logic dn, input int exp_pos);
        int c;
        @(posedge clk); #1;
        c = cyc;
        a_dir1 = up;
        a_dir0 = dn;
        push_chg(exp_pos, c + 3);
        repeat (3) @(posedge clk);
        #1;
        a_dir1 = 1'b0;
        a_dir0 = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic a_ctl(input logic z, input logic l, input int val, input int exp_pos);
        int c;
        @(posedge clk); #1;
        c = cyc;
        a_zero     = z;
        a_load     = l;
        a_load_val = 10'(val);
        push_chg(exp_pos, c + 1);
        @(posedge clk); #1;
        a_zero = 1'b0;
        a_load = 1'b0;
        @(posedge clk);
    endtask

    // zero and load(3) asserted in the very cycle the dir1 step resolves.
    task automatic a_zlu(input int exp_pos);
        int c;
        @(posedge clk); #1;
        c = cyc;
        a_dir1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_zero     = 1'b1;
        a_load     = 1'b1;
        a_load_val = 10'd3;
        push_chg(exp_pos, c + 3);
        @(posedge clk); #1;
        a_zero = 1'b0;
        a_load = 1'b0;
        a_dir1 = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic b_pulse(input logic up, input logic dn);
        @(posedge clk); #1;
        b_dir1 = up;
        b_dir0 = dn;
        repeat (3) @(posedge clk);
        #1;
        b_dir1 = 1'b0;
        b_dir0 = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic b_ctl(input logic z, input logic l, input int val);
        @(posedge clk); #1;
        b_zero     = z;
        b_load     = l;
        b_load_val = 8'(val);
        @(posedge clk); #1;
        b_zero = 1'b0;
        b_load = 1'b0;
        @(posedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------------------------------------------------------------
    // Vector tables
    // ---------------------------------------------------------------------
    typedef enum {OP_UP, OP_DN, OP_BOTH, OP_ZERO, OP_LOAD, OP_ZLU} op_t;

    typedef struct {
        op_t  op;
        int   val;
        int   pos;
        logic lim;
    } a_vec_t;

    typedef struct {
        op_t  op;
        int   val;
        int   w;
        int   s;
        int   o;
        logic lw;
        logic ls;
        logic lo;
    } b_vec_t;

    a_vec_t a_vec[$];
    b_vec_t b_vec[$];
    int     r;

    initial begin
        rst = 1'b1;
        {a_dir0, a_dir1, a_zero, a_load} = '0;
        a_load_val = '0;
        {b_dir0, b_dir1, b_zero, b_load} = '0;
        b_load_val = '0;

        // 0..9 wrap / clamp pair plus the [3,12] clamp instance
        b_vec.push_back('{OP_LOAD, 9, 9, 9, 9,  1'b0, 1'b0, 1'b0});
        b_vec.push_back('{OP_UP,   0, 0, 9, 10, 1'b1, 1'b1, 1'b0});
        b_vec.push_back('{OP_DN,   0, 9, 8, 9,  1'b1, 1'b1, 1'b0});
        b_vec.push_back('{OP_ZERO, 0, 0, 0, 3,  1'b0, 1'b0, 1'b0});
        b_vec.push_back('{OP_DN,   0, 9, 0, 3,  1'b1, 1'b1, 1'b1});
        b_vec.push_back('{OP_UP,   0, 0, 1, 4,  1'b1, 1'b1, 1'b1});

        // -128..127 wrapping instance
        a_vec.push_back('{OP_UP,    0,    1,    1'b0});
        a_vec.push_back('{OP_UP,    0,    2,    1'b0});
        a_vec.push_back('{OP_UP,    0,    3,    1'b0});
        a_vec.push_back('{OP_UP,    0,    4,    1'b0});
        a_vec.push_back('{OP_UP,    0,    5,    1'b0});
        a_vec.push_back('{OP_BOTH,  0,    5,    1'b0});
        a_vec.push_back('{OP_ZLU,   0,    0,    1'b0});
        a_vec.push_back('{OP_LOAD,  200,  127,  1'b0});
        a_vec.push_back('{OP_UP,    0,    -128, 1'b1});
        a_vec.push_back('{OP_DN,    0,    127,  1'b1});
        a_vec.push_back('{OP_ZERO,  0,    0,    1'b0});
        a_vec.push_back('{OP_LOAD,  -300, -128, 1'b0});
        a_vec.push_back('{OP_DN,    0,    127,  1'b1});
        a_vec.push_back('{OP_LOAD,  126,  126,  1'b1});
        a_vec.push_back('{OP_UP,    0,    127,  1'b1});
        a_vec.push_back('{OP_ZERO,  0,    0,    1'b0});
        a_vec.push_back('{OP_LOAD,  0,    0,    1'b0});

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_position",  $signed(a_position), 0);
        check("rst_a_changed",   a_changed, 0);
        check("rst_a_limit",     a_limit, 0);
        check("rst_a_velocity",  $signed(a_velocity), 0);
        check("rst_a_vel_valid", a_vel_valid, 0);
        check("rst_w_position",  w_position, 0);
        check("rst_s_position",  s_position, 0);
        check("rst_o_position",  o_position, 3);
        check("rst_wso_flags",   {w_changed, s_changed, o_changed, w_limit, s_limit, o_limit}, 0);
        check("rst_wso_velocity", {w_velocity, s_velocity, o_velocity}, 0);
        check("rst_wso_vel_valid", {w_vel_valid, s_vel_valid, o_vel_valid}, 0);
        rst = 1'b0;

        // ---- limit behaviour: wrap vs clamp ----
        begin
            int pw = 0, ps = 0, po = 3;
            int nw = 0, ns = 0, no = 0;
            foreach (b_vec[i]) begin
                case (b_vec[i].op)
                    OP_UP:   b_pulse(1'b1, 1'b0);
                    OP_DN:   b_pulse(1'b0, 1'b1);
                    OP_ZERO: b_ctl(1'b1, 1'b0, 0);
                    OP_LOAD: b_ctl(1'b0, 1'b1, b_vec[i].val);
                    default: ;
                endcase
                @(negedge clk);
                check($sformatf("b_vec[%0d].w_position", i), w_position, b_vec[i].w);
                check($sformatf("b_vec[%0d].s_position", i), s_position, b_vec[i].s);
                check($sformatf("b_vec[%0d].o_position", i), o_position, b_vec[i].o);
                check($sformatf("b_vec[%0d].w_limit", i), w_limit, b_vec[i].lw);
                check($sformatf("b_vec[%0d].s_limit", i), s_limit, b_vec[i].ls);
                check($sformatf("b_vec[%0d].o_limit", i), o_limit, b_vec[i].lo);
                if (b_vec[i].w != pw) nw++;
                if (b_vec[i].s != ps) ns++;
                if (b_vec[i].o != po) no++;
                pw = b_vec[i].w;
                ps = b_vec[i].s;
                po = b_vec[i].o;
            end
            check("w_changed_count", w_chg_n, nw);
            check("s_changed_count", s_chg_n, ns);
            check("o_changed_count", o_chg_n, no);
        end

        // ---- position table on dut_a ----
        foreach (a_vec[i]) begin
            case (a_vec[i].op)
                OP_UP:   a_pulse(1'b1, 1'b0, a_vec[i].pos);
                OP_DN:   a_pulse(1'b0, 1'b1, a_vec[i].pos);
                OP_BOTH: a_pulse(1'b1, 1'b1, a_vec[i].pos);
                OP_ZERO: a_ctl(1'b1, 1'b0, 0, a_vec[i].pos);
                OP_LOAD: a_ctl(1'b0, 1'b1, a_vec[i].val, a_vec[i].pos);
                OP_ZLU:  a_zlu(a_vec[i].pos);
                default: ;
            endcase
            @(negedge clk);
            check($sformatf("a_vec[%0d].position", i), $signed(a_position), a_vec[i].pos);
            check($sformatf("a_vec[%0d].limit", i), a_limit, a_vec[i].lim);
        end

        // ---- reset while dir1 is held high ----
        a_ctl(1'b0, 1'b1, 127, 127);
        a_pulse(1'b1, 1'b0, -128);
        a_ctl(1'b0, 1'b1, 50, 50);
        @(negedge clk);
        check("pre_rst_limit", a_limit, 1);
        check("pre_rst_position", $signed(a_position), 50);
        @(posedge clk); #1;
        a_dir1 = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_position",  $signed(a_position), 0);
        check("async_rst_limit",     a_limit, 0);
        check("async_rst_changed",   a_changed, 0);
        check("async_rst_velocity",  $signed(a_velocity), 0);
        check("async_rst_vel_valid", a_vel_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        r      = cyc;
        a_last = 0;
        push_chg(1, r + 3);
        repeat (4) @(posedge clk);
        #1;
        a_dir1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_midpulse_position", $signed(a_position), 1);

        // ---- velocity windows (VW=4 saturates at +7/-8) ----
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        r         = cyc;
        a_last    = 0;
        vel_check = 1'b1;
        push_vel(5,  r + 100);
        push_vel(0,  r + 200);
        push_vel(7,  r + 300);
        push_vel(-8, r + 400);
        for (int i = 1; i <= 7; i++) a_pulse(1'b1, 1'b0, i);
        for (int i = 1; i <= 2; i++) a_pulse(1'b0, 1'b1, 7 - i);
        wait_cyc(r + 200);
        for (int i = 1; i <= 10; i++) a_pulse(1'b1, 1'b0, 5 + i);
        wait_cyc(r + 300);
        for (int i = 1; i <= 10; i++) a_pulse(1'b0, 1'b1, 15 - i);
        wait_cyc(r + 405);
        @(negedge clk);
        check("final_position", $signed(a_position), 5);

        check("chg_q_leftover", chg_q.size(), 0);
        check("vel_q_leftover", vel_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
